// File: rtl/npc_pkg.sv
// Shared LSU definitions: RV32I load/store funct3 codes, FSM and op-kind
// enumerations, and the misalignment predicate used when LSU_MISALIGN_TRAP_EN is defined.
package npc_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MEM  = 2'd1,
      S_RESP = 2'd2
   } lsu_state_e;

   typedef enum logic [1:0] {
      OP_NONE  = 2'd0,
      OP_LOAD  = 2'd1,
      OP_STORE = 2'd2
   } lsu_kind_e;

   // Unknown store widths behave as SW, unknown load widths as LW.
   function automatic logic misaligned(input logic is_load, input logic [2:0] f3,
                                       input logic [1:0] addr_lo);
      logic is_byte;
      logic is_half;
      is_byte = (f3 == F3_B) || (is_load && (f3 == F3_BU));
      is_half = (f3 == F3_H) || (is_load && (f3 == F3_HU));
      if (is_byte)      return 1'b0;
      else if (is_half) return addr_lo[0];
      else              return (addr_lo != 2'b00);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store data replication, write mask and
// load data extraction with sign/zero extension.
module lsu_align
   import npc_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [31:0] wdata_sh,
   output logic [3:0]  wmask,
   output logic [31:0] rdata_ext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      wdata_sh  = wdata;
      wmask     = 4'b1111;
      rdata_ext = rdata;
      byte_sel  = rdata[{addr_lo, 3'b000} +: 8];
      half_sel  = rdata[{addr_lo[1], 4'b0000} +: 16];

      case (funct3)
         F3_B: begin
            wdata_sh = {4{wdata[7:0]}};
            wmask    = 4'b0001 << addr_lo;
         end
         F3_H: begin
            wdata_sh = {2{wdata[15:0]}};
            wmask    = addr_lo[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase

      case (funct3)
         F3_B:    rdata_ext = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   rdata_ext = {24'h000000, byte_sel};
         F3_H:    rdata_ext = {{16{half_sel[15]}}, half_sel};
         F3_HU:   rdata_ext = {16'h0000, half_sel};
         default: ;
      endcase
   end

endmodule

// File: rtl/npc_lsu.sv
// Single-outstanding load/store unit: IDLE -> MEM -> RESP handshake FSM.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned halfword/word ops via out_err.
module npc_lsu
   import npc_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_load,
   input  logic        in_store,
   input  logic [2:0]  in_funct3,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [4:0]  in_rd,
   output logic        mem_req,
   output logic        mem_wen,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_rd,
   output logic        out_wen,
   output logic [31:0] out_data,
   output logic        out_err
);

   lsu_state_e  state_q,    state_d;
   lsu_kind_e   kind_q,     kind_d;
   logic [31:0] addr_q,     addr_d;
   logic [2:0]  funct3_q,   funct3_d;
   logic [31:0] wdata_q,    wdata_d;
   logic [4:0]  rd_q,       rd_d;
   logic [31:0] out_data_q, out_data_d;
   logic        out_wen_q,  out_wen_d;
   logic        out_err_q,  out_err_d;

   logic [31:0] wdata_sh;
   logic [3:0]  wmask;
   logic [31:0] rdata_ext;
   logic        trap;

   lsu_align u_align (
      .addr_lo   (addr_q[1:0]),
      .funct3    (funct3_q),
      .wdata     (wdata_q),
      .rdata     (mem_rdata),
      .wdata_sh  (wdata_sh),
      .wmask     (wmask),
      .rdata_ext (rdata_ext)
   );

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap = misaligned(kind_q == OP_LOAD, funct3_q, addr_q[1:0]);
`else
   assign trap = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      kind_d     = kind_q;
      addr_d     = addr_q;
      funct3_d   = funct3_q;
      wdata_d    = wdata_q;
      rd_d       = rd_q;
      out_data_d = out_data_q;
      out_wen_d  = out_wen_q;
      out_err_d  = out_err_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               addr_d     = in_addr;
               funct3_d   = in_funct3;
               wdata_d    = in_wdata;
               rd_d       = in_rd;
               out_data_d = '0;
               out_wen_d  = 1'b0;
               out_err_d  = 1'b0;
               if (in_load) begin
                  kind_d  = OP_LOAD;
                  state_d = S_MEM;
               end else if (in_store) begin
                  kind_d  = OP_STORE;
                  state_d = S_MEM;
               end else begin
                  kind_d  = OP_NONE;
                  state_d = S_RESP;
               end
            end
         end
         S_MEM: begin
            // A trapped op spends its MEM cycle without a request, so the
            // error response keeps the same two-cycle latency as a real access.
            if (trap) begin
               out_err_d = 1'b1;
               state_d   = S_RESP;
            end else if (mem_ack) begin
               out_wen_d  = (kind_q == OP_LOAD);
               out_data_d = (kind_q == OP_LOAD) ? rdata_ext : '0;
               state_d    = S_RESP;
            end
         end
         S_RESP: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         kind_q     <= OP_NONE;
         addr_q     <= '0;
         funct3_q   <= '0;
         wdata_q    <= '0;
         rd_q       <= '0;
         out_data_q <= '0;
         out_wen_q  <= 1'b0;
         out_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         kind_q     <= kind_d;
         addr_q     <= addr_d;
         funct3_q   <= funct3_d;
         wdata_q    <= wdata_d;
         rd_q       <= rd_d;
         out_data_q <= out_data_d;
         out_wen_q  <= out_wen_d;
         out_err_q  <= out_err_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign mem_req   = (state_q == S_MEM) && !trap;
   assign mem_wen   = mem_req && (kind_q == OP_STORE);
   assign mem_wmask = mem_wen ? wmask : 4'b0000;
   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_wdata = wdata_sh;
   assign out_valid = (state_q == S_RESP);
   assign out_rd    = rd_q;
   assign out_wen   = out_wen_q;
   assign out_data  = out_data_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_npc_lsu.sv
// Scoreboard bench for npc_lsu: expected writebacks are queued at accept and
// compared when out_valid is seen; memory side is driven inline per op.
module tb_npc_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_load, in_store;
   logic [2:0]  in_funct3;
   logic [31:0] in_addr, in_wdata;
   logic [4:0]  in_rd;
   logic        mem_req, mem_wen, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;
   logic        out_valid, out_ready, out_wen, out_err;
   logic [4:0]  out_rd;
   logic [31:0] out_data;

   typedef struct {
      logic [4:0]  rd;
      logic        wen;
      logic [31:0] data;
      logic        err;
   } resp_t;

   resp_t       sb_q[$];
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   npc_lsu dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
      .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
      .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_wen(out_wen),
      .out_data(out_data), .out_err(out_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] w);
      logic [31:0] b;
      logic [31:0] h;
      b = w >> (int'(a) * 8);
      h = w >> (a[1] ? 16 : 0);
      case (f3)
         3'b000:  return {{24{b[7]}}, b[7:0]};
         3'b100:  return {24'h0, b[7:0]};
         3'b001:  return {{16{h[15]}}, h[15:0]};
         3'b101:  return {16'h0, h[15:0]};
         default: return w;
      endcase
   endfunction

   function automatic logic [3:0] mask_model(input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         3'b000:  return 4'b0001 << a;
         3'b001:  return a[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] wdata_model(input logic [2:0] f3, input logic [31:0] w);
      case (f3)
         3'b000:  return {4{w[7:0]}};
         3'b001:  return {2{w[15:0]}};
         default: return w;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      for (int i = 0; i < 20 && !in_ready; i++) tick();
      if (!in_ready) check({tag, ".ready_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic accept(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
      in_valid = 1'b1; in_load = ld; in_store = st;
      in_funct3 = f3; in_addr = addr; in_wdata = wd; in_rd = rd;
      tick();
      in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
      in_addr = $urandom; in_wdata = $urandom; in_rd = 5'($urandom);
   endtask

   // Compare the response against the scoreboard head for stall+1 cycles, then handshake.
   task automatic drain_resp(input string tag, input int stall);
      resp_t r;
      if (sb_q.size() == 0) begin
         check({tag, ".sb_underflow"}, 32'd0, 32'd1);
         return;
      end
      r = sb_q[0];
      for (int s = 0; s <= stall; s++) begin
         check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
         check({tag, ".in_ready"},  {31'd0, in_ready},  32'd0);
         check({tag, ".out_data"},  out_data, r.data);
         check({tag, ".out_wen"},   {31'd0, out_wen}, {31'd0, r.wen});
         check({tag, ".out_rd"},    {27'd0, out_rd},  {27'd0, r.rd});
         check({tag, ".out_err"},   {31'd0, out_err}, {31'd0, r.err});
         if (s == stall) out_ready = 1'b1;
         tick();
      end
      out_ready = 1'b0;
      void'(sb_q.pop_front());
      check({tag, ".idle_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, ".idle_ready"}, {31'd0, in_ready},  32'd1);
   endtask

   task automatic do_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                        input logic [31:0] rdata, input int ack_dly, input int stall,
                        input logic [3:0] exp_mask, input logic [31:0] exp_wdata);
      resp_t r;
      logic  is_st;
      is_st = st && !ld;
      wait_ready(tag);
      accept(ld, st, f3, addr, wd, rd);
      r.rd = rd; r.wen = ld; r.err = 1'b0;
      r.data = ld ? load_model(f3, addr[1:0], rdata) : 32'd0;
      sb_q.push_back(r);
      check({tag, ".busy"}, {31'd0, in_ready}, 32'd0);
      if (ld || st) begin
         for (int c = 0; c <= ack_dly; c++) begin
            check({tag, ".mem_req"},   {31'd0, mem_req},   32'd1);
            check({tag, ".mem_addr"},  mem_addr, {addr[31:2], 2'b00});
            check({tag, ".mem_wen"},   {31'd0, mem_wen},   {31'd0, is_st});
            check({tag, ".mem_wmask"}, {28'd0, mem_wmask}, {28'd0, exp_mask});
            if (is_st) check({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
            check({tag, ".early_valid"}, {31'd0, out_valid}, 32'd0);
            if (c == ack_dly) begin
               mem_ack = 1'b1;
               mem_rdata = rdata;
            end
            tick();
         end
         mem_ack = 1'b0;
         mem_rdata = $urandom;
      end
      check({tag, ".req_drop"}, {31'd0, mem_req}, 32'd0);
      drain_resp(tag, stall);
   endtask

   initial begin
      logic [2:0]  f3;
      logic [31:0] a, w, rd_word;
      logic        ld;
      logic [2:0]  f3_list [6];
      f3_list = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};

      rst = 1'b1; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
      in_funct3 = '0; in_addr = '0; in_wdata = '0; in_rd = '0;
      mem_ack = 1'b0; mem_rdata = '0; out_ready = 1'b0;
      tick(); tick();
      check("rst.in_ready",  {31'd0, in_ready},  32'd1);
      check("rst.mem_req",   {31'd0, mem_req},   32'd0);
      check("rst.mem_wen",   {31'd0, mem_wen},   32'd0);
      check("rst.mem_wmask", {28'd0, mem_wmask}, 32'd0);
      check("rst.out_valid", {31'd0, out_valid}, 32'd0);
      check("rst.out_wen",   {31'd0, out_wen},   32'd0);
      check("rst.out_err",   {31'd0, out_err},   32'd0);
      check("rst.mem_addr",  mem_addr,  32'd0);
      check("rst.mem_wdata", mem_wdata, 32'd0);
      check("rst.out_data",  out_data,  32'd0);
      check("rst.out_rd",    {27'd0, out_rd}, 32'd0);
      rst = 1'b0;

      do_op("sw", 1'b0, 1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 5'd3, 32'h0, 3, 0,
            4'b1111, 32'hDEAD_BEEF);
      do_op("lb", 1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 5'd7, 32'h80FF_1234, 0, 0,
            4'b0000, 32'h0);
      check("lb.value", load_model(3'b000, 2'd3, 32'h80FF_1234), 32'hFFFF_FF80);
      do_op("lbu", 1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 5'd8, 32'h80FF_1234, 1, 0,
            4'b0000, 32'h0);
      do_op("sh", 1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 5'd9, 32'h0, 0, 0,
            4'b1100, 32'hABCD_ABCD);
      do_op("sb1", 1'b0, 1'b1, 3'b000, 32'h8000_0011, 32'h1234_5678, 5'd1, 32'h0, 2, 0,
            4'b0010, 32'h7878_7878);
      do_op("sw_f3_100", 1'b0, 1'b1, 3'b100, 32'h8000_0020, 32'hCAFE_F00D, 5'd2, 32'h0, 0, 0,
            4'b1111, 32'hCAFE_F00D);
      do_op("lw_stall", 1'b1, 1'b0, 3'b010, 32'h8000_0008, 32'h0, 5'd10, 32'h1357_9BDF, 0, 4,
            4'b0000, 32'h0);
      do_op("lh_hi", 1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0, 5'd11, 32'h9ABC_0000, 1, 1,
            4'b0000, 32'h0);
      do_op("lhu_hi", 1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'h0, 5'd12, 32'h9ABC_0000, 0, 0,
            4'b0000, 32'h0);
      do_op("ld_and_st", 1'b1, 1'b1, 3'b010, 32'h8000_0030, 32'hFFFF_FFFF, 5'd13,
            32'h0BAD_CAFE, 0, 0, 4'b0000, 32'h0);
      do_op("lw_f3_111", 1'b1, 1'b0, 3'b111, 32'h8000_0034, 32'h0, 5'd14, 32'h7654_3210, 0, 0,
            4'b0000, 32'h0);
      do_op("null", 1'b0, 1'b0, 3'b010, 32'h8000_0040, 32'h0, 5'd15, 32'h0, 0, 0,
            4'b0000, 32'h0);

`ifdef LSU_MISALIGN_TRAP_EN
      begin
         resp_t r;
         wait_ready("trap");
         accept(1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'h0, 5'd16);
         r.rd = 5'd16; r.wen = 1'b0; r.data = 32'd0; r.err = 1'b1;
         sb_q.push_back(r);
         check("trap.mem_req",     {31'd0, mem_req},   32'd0);
         check("trap.early_valid", {31'd0, out_valid}, 32'd0);
         mem_ack = 1'b1;
         tick();
         mem_ack = 1'b0;
         check("trap.mem_req2", {31'd0, mem_req}, 32'd0);
         drain_resp("trap", 0);
      end
`else
      do_op("lw_misal", 1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'h0, 5'd16, 32'hA5A5_5A5A, 0, 0,
            4'b0000, 32'h0);
`endif

      for (int i = 0; i < 12; i++) begin
         f3 = f3_list[$urandom_range(0, 5)];
         ld = 1'($urandom_range(0, 1));
         a = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
         if (f3 == 3'b001 || (ld && f3 == 3'b101)) a[0] = 1'b0;
         else if (f3 != 3'b000 && !(ld && f3 == 3'b100)) a[1:0] = 2'b00;
         w = $urandom;
         rd_word = $urandom;
         do_op($sformatf("rnd%0d", i), ld, !ld, f3, a, w, 5'($urandom), rd_word,
               $urandom_range(0, 3), $urandom_range(0, 2),
               ld ? 4'b0000 : mask_model(f3, a[1:0]), wdata_model(f3, w));
      end

      // Reset while a load is waiting in MEM; the late ack must be dropped.
      wait_ready("rst_mem");
      accept(1'b1, 1'b0, 3'b010, 32'h8000_0050, 32'h0, 5'd20);
      check("rst_mem.mem_req", {31'd0, mem_req}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mem_ack = 1'b1;
      mem_rdata = 32'h1111_2222;
      check("rst_mem.req_after", {31'd0, mem_req},  32'd0);
      check("rst_mem.ready",     {31'd0, in_ready}, 32'd1);
      tick();
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("rst_mem.no_valid", {31'd0, out_valid}, 32'd0);
         check("rst_mem.no_req",   {31'd0, mem_req},   32'd0);
         tick();
      end

      check("sb_empty", sb_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
